// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: channel state encoding,
// default timing constants and the counter width helper.
package button_conditioner_pkg;

    // Per-channel debounce state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms of stable input at 5 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 32'd50000;
    // 1 s of continuous hold at 5 MHz
    localparam int DEF_HOLD_CYCLES     = 32'd5000000;

    // Number of bits needed to represent values 0 .. value-1 (never below 1)
    function automatic int clog2_f(input int value);
        int width_v;
        int rem_v;
        width_v = 32'd0;
        rem_v   = value - 32'd1;
        while (rem_v > 32'd0) begin
            width_v = width_v + 32'd1;
            rem_v   = rem_v >> 1;
        end
        if (width_v < 32'd1) begin
            width_v = 32'd1;
        end
        return width_v;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: two-flop synchronizer, consecutive-sample debounce
// counter, hold counter and a four-state qualification FSM. Every output is
// taken straight from a flop.
module btn_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk5,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CW = clog2_f(DEBOUNCE_CYCLES + 32'd1);
    localparam int HW = clog2_f(HOLD_CYCLES + 32'd1);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    // Count value on the edge before qualification completes
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 32'd1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    btn_state_e    state_r;
    btn_state_e    state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_nxt_s;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          hold_r;
    logic          level_nxt_s;
    logic          press_nxt_s;
    logic          release_nxt_s;
    logic          hold_nxt_s;

    // Bring the asynchronous pin into the clk5 domain
    always_ff @(posedge clk5) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk5) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            count_r    <= CNT_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            hold_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            level_r    <= level_nxt_s;
            press_r    <= press_nxt_s;
            release_r  <= release_nxt_s;
            hold_r     <= hold_nxt_s;
        end
    end

    // Next-state and counter update; any opposite sample restarts qualification
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sync2_r) begin
                    state_nxt_s = ST_PRESS_WAIT;
                    count_nxt_s = CNT_ONE;
                end else begin
                    count_nxt_s = CNT_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (sync2_r) begin
                    if (count_r == CNT_LAST) begin
                        state_nxt_s    = ST_PRESSED;
                        count_nxt_s    = CNT_ZERO;
                        hold_cnt_nxt_s = HOLD_ZERO;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = CNT_ZERO;
                end
            end
            ST_PRESSED: begin
                if (sync2_r) begin
                    // Saturate so a long hold never re-arms the hold pulse
                    if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r;
                    end
                end else begin
                    state_nxt_s = ST_RELEASE_WAIT;
                    count_nxt_s = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!sync2_r) begin
                    if (count_r == CNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        count_nxt_s = CNT_ZERO;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end else begin
                    // Bounce back: hold_cnt keeps its frozen value
                    state_nxt_s = ST_PRESSED;
                    count_nxt_s = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                count_nxt_s    = CNT_ZERO;
                hold_cnt_nxt_s = HOLD_ZERO;
            end
        endcase
    end

    // Output decode from the transition being taken this edge
    always_comb begin
        level_nxt_s   = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_RELEASE_WAIT);
        press_nxt_s   = (state_r == ST_PRESS_WAIT) && (state_nxt_s == ST_PRESSED);
        release_nxt_s = (state_r == ST_RELEASE_WAIT) && (state_nxt_s == ST_IDLE);
        hold_nxt_s    = (state_r == ST_PRESSED) && sync2_r && (hold_cnt_r == HOLD_LAST);
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign hold_pulse    = hold_r;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: N_BTN independent debounce channels turning raw
// board pins into a clean level plus press, release and long-hold pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = 32'd3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic             clk5,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk5          (clk5),
            .rstn          (rstn),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .hold_pulse    (btn_hold[i])
        );
    end

endmodule
